uart_pkt_sched: RTL

Scheduler sharing one UART transmitter and one UART receiver between several controller-packet sources (e.g. N64 port, GC port). Host poll bytes on RX grant transmit credits. Each credit sends one framed packet from the next pending source, chosen round-robin. Sits between the controller front-ends and the UART_tx/UART_rx pair.

---
 rtl/uart_pkt_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_pkt_sched.sv
// rtl/uart_pkt_sched.sv - round-robin packet scheduler sharing one UART tx/rx pair
// Optional checksum trailer byte enabled by defining UART_PKT_SCHED_CKSUM_EN.
module uart_pkt_sched #(
    parameter int         NUM_SRC   = 2,
    parameter int         PKT_BYTES = 4,
    parameter logic [7:0] POLL_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC*32-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_set,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   rx_clr_rdy,
    output logic [7:0]             tx_data,
    output logic                   tx_trmt,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [NUM_SRC-1:0]     overrun
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CKSUM} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_credit;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_overrun;
    logic [2:0]           r_rr;
    logic [31:0]          r_shadow;
    logic [2:0]           r_idx;
    logic [7:0]           r_tx_data;
    logic                 r_tx_trmt;
    logic                 r_busy;
    logic [2:0]           r_grant_id;
`ifdef UART_PKT_SCHED_CKSUM_EN
    logic [7:0]           r_cksum;
`endif

    logic                 w_found;
    logic [2:0]           w_pick;
    logic [31:0]          w_word;
    int                   w_best;
    int                   w_dist;
    logic                 w_grant;
    logic                 w_poll;
    logic [NUM_SRC-1:0]   w_grant_mask;
    logic [2:0]           w_rr_nxt;
    logic [7:0]           w_hdr;
    logic [7:0]           w_payload;
    logic                 w_send;
    logic [7:0]           w_send_byte;
    logic                 w_pkt_end;

    assign rx_clr_rdy = rx_rdy;
    assign tx_data    = r_tx_data;
    assign tx_trmt    = r_tx_trmt;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign overrun    = r_overrun;

    assign w_poll    = rx_rdy && (rx_data == POLL_BYTE);
    assign w_grant   = (r_state == S_IDLE) && (r_credit != 2'd0) && w_found;
    assign w_rr_nxt  = (w_pick == 3'(NUM_SRC - 1)) ? 3'd0 : w_pick + 3'd1;
    assign w_hdr     = 8'h80 | {5'b0, w_pick};
    assign w_payload = 8'(r_shadow >> {r_idx[1:0], 3'b000});

    // Closest pending source at or after the RR pointer, measured modulo NUM_SRC.
    always_comb begin
        w_found      = 1'b0;
        w_pick       = '0;
        w_word       = '0;
        w_best       = 0;
        w_dist       = 0;
        w_grant_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_dist = (i + NUM_SRC - int'(r_rr)) % NUM_SRC;
            if (r_pending[i] && (!w_found || (w_dist < w_best))) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_pick  = 3'(i);
                w_word  = src_data[32*i +: 32];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            w_grant_mask[i] = w_grant && (w_pick == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_send      = 1'b0;
        w_send_byte = '0;
        w_pkt_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (tx_done) begin
                    w_send      = 1'b1;
                    w_send_byte = r_shadow[7:0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_done) begin
                    if (r_idx < 3'(PKT_BYTES)) begin
                        w_send      = 1'b1;
                        w_send_byte = w_payload;
                    end else begin
`ifdef UART_PKT_SCHED_CKSUM_EN
                        w_send      = 1'b1;
                        w_send_byte = r_cksum;
                        w_state_nxt = S_CKSUM;
`else
                        w_pkt_end   = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
            S_CKSUM: begin
                if (tx_done) begin
                    w_pkt_end   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit   <= '0;
            r_pending  <= '0;
            r_overrun  <= '0;
            r_rr       <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_trmt  <= 1'b0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
`ifdef UART_PKT_SCHED_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            r_tx_trmt <= 1'b0;
            if (w_grant) begin
                r_shadow   <= w_word;
                r_grant_id <= w_pick;
                r_rr       <= w_rr_nxt;
                r_tx_data  <= w_hdr;
                r_tx_trmt  <= 1'b1;
                r_busy     <= 1'b1;
`ifdef UART_PKT_SCHED_CKSUM_EN
                r_cksum    <= w_hdr;
`endif
            end
            if (w_send) begin
                r_tx_data <= w_send_byte;
                r_tx_trmt <= 1'b1;
                r_idx     <= (r_state == S_HDR) ? 3'd1 : r_idx + 3'd1;
`ifdef UART_PKT_SCHED_CKSUM_EN
                r_cksum   <= r_cksum ^ w_send_byte;
`endif
            end
            if (w_pkt_end) r_busy <= 1'b0;

            // A set landing on the granted source queues a fresh packet, not an overrun.
            r_pending <= (r_pending & ~w_grant_mask) | src_set;
            r_overrun <= r_overrun | (src_set & r_pending & ~w_grant_mask);

            case ({w_poll, w_grant})
                2'b10:   if (r_credit != 2'd3) r_credit <= r_credit + 2'd1;
                2'b01:   r_credit <= r_credit - 2'd1;
                default: r_credit <= r_credit;
            endcase
        end
    end

endmodule
